// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/param_deserializer_if.sv
// Serial input and word-wide valid/ready output bundle of the deserializer.
interface param_deserializer_if
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    localparam int CW = cnt_width(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             sin_sof;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [CW-1:0]    bit_count;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sin,
        output sin_valid,
        output sin_sof,
        output out_ready,
        input  data_out,
        input  data_valid,
        input  bit_count,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  sin_sof,
        input  out_ready,
        output data_out,
        output data_valid,
        output bit_count,
        output frame_err,
        output overrun
    );

endinterface

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register; reports a word it had to drop.
module deser_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             drop
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Drop when a new word arrives while the held one is not being consumed.
    always_comb begin
        drop = 1'b0;
        if (load && valid_r && !out_ready) begin
            drop = 1'b1;
        end else begin
            drop = 1'b0;
        end
    end

    // Holding register: load when empty or draining, otherwise clear on consumption.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load && (!valid_r || out_ready)) begin
            data_r  <= din;
            valid_r <= 1'b1;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;

endmodule

// File: rtl/param_deserializer.sv
// Framed serial receiver: collects WIDTH bits per frame and hands the word to a valid/ready buffer.
module param_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    param_deserializer_if.slave   bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    deser_state_e     state_r;
    deser_state_e     state_next_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_next_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             ferr_r;
    logic             ferr_next_s;
    logic             load_s;
    logic             ovr_r;
    logic             drop_s;
    logic [WIDTH-1:0] data_out_s;
    logic             data_valid_s;

    // Shift register contents with the current serial bit entered.
    always_comb begin
        shifted_s = sr_r;
        if (MSB_FIRST != 0) begin
            shifted_s = {sr_r[WIDTH-2:0], bus.sin};
        end else begin
            shifted_s = {bus.sin, sr_r[WIDTH-1:1]};
        end
    end

    // Framing FSM: a sof always starts a fresh word, even mid-word.
    always_comb begin
        state_next_s = state_r;
        sr_next_s    = sr_r;
        cnt_next_s   = cnt_r;
        ferr_next_s  = 1'b0;
        load_s       = 1'b0;
        if (bus.sin_valid) begin
            case (state_r)
                IDLE: begin
                    if (bus.sin_sof) begin
                        sr_next_s    = shifted_s;
                        cnt_next_s   = CW'(1);
                        state_next_s = SHIFT;
                    end else begin
                        ferr_next_s  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.sin_sof) begin
                        sr_next_s    = shifted_s;
                        cnt_next_s   = CW'(1);
                        ferr_next_s  = 1'b1;
                    end else if (cnt_r == LAST_IDX) begin
                        sr_next_s    = shifted_s;
                        cnt_next_s   = {CW{1'b0}};
                        state_next_s = IDLE;
                        load_s       = 1'b1;
                    end else begin
                        sr_next_s    = shifted_s;
                        cnt_next_s   = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, shift register, counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sr_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sr_r    <= sr_next_s;
            cnt_r   <= cnt_next_s;
            ferr_r  <= ferr_next_s;
            ovr_r   <= ovr_r | drop_s;
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .din        (shifted_s),
        .out_ready  (bus.out_ready),
        .data_out   (data_out_s),
        .data_valid (data_valid_s),
        .drop       (drop_s)
    );

    assign bus.data_out   = data_out_s;
    assign bus.data_valid = data_valid_s;
    assign bus.bit_count  = cnt_r;
    assign bus.frame_err  = ferr_r;
    assign bus.overrun    = ovr_r;

endmodule
